// File: rtl/sargantana_icache_ifill_server_if.sv
// Refill-side bus bundle: icache request/response, coherence invalidations and memory line reads.
// The slave modport is the server's view; the master modport is the environment's view.
interface sargantana_icache_ifill_server_if #(
  parameter int PADDR_WIDTH = 40,
  parameter int LINE_WIDTH  = 256,
  parameter int BEAT_WIDTH  = 64,
  parameter int WAY_WIDTH   = 2
) ();
  logic                   ifill_req_valid_i;
  logic [PADDR_WIDTH-1:0] ifill_req_paddr_i;
  logic [WAY_WIDTH-1:0]   ifill_req_way_i;
  logic                   ifill_resp_valid_o;
  logic [LINE_WIDTH-1:0]  ifill_resp_data_o;
  logic [1:0]             ifill_resp_beat_o;
  logic [WAY_WIDTH-1:0]   ifill_resp_way_o;
  logic                   ifill_resp_inv_valid_o;
  logic [PADDR_WIDTH-1:0] ifill_resp_inv_paddr_o;
  logic                   inv_valid_i;
  logic [PADDR_WIDTH-1:0] inv_paddr_i;
  logic                   inv_ready_o;
  logic                   mem_req_valid_o;
  logic                   mem_req_ready_i;
  logic [PADDR_WIDTH-1:0] mem_req_addr_o;
  logic                   mem_rsp_valid_i;
  logic [BEAT_WIDTH-1:0]  mem_rsp_data_i;

  modport slave (
    input  ifill_req_valid_i, ifill_req_paddr_i, ifill_req_way_i,
    output ifill_resp_valid_o, ifill_resp_data_o, ifill_resp_beat_o, ifill_resp_way_o,
    output ifill_resp_inv_valid_o, ifill_resp_inv_paddr_o,
    input  inv_valid_i, inv_paddr_i,
    output inv_ready_o,
    output mem_req_valid_o, mem_req_addr_o,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i
  );

  modport master (
    output ifill_req_valid_i, ifill_req_paddr_i, ifill_req_way_i,
    input  ifill_resp_valid_o, ifill_resp_data_o, ifill_resp_beat_o, ifill_resp_way_o,
    input  ifill_resp_inv_valid_o, ifill_resp_inv_paddr_o,
    output inv_valid_i, inv_paddr_i,
    input  inv_ready_o,
    input  mem_req_valid_o, mem_req_addr_o,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i
  );
endinterface

// File: rtl/sargantana_icache_ifill_server.sv
// Icache refill responder: one line fill at a time, gathered from in-order memory beats and
// returned as a single-cycle line response; idle cycles forward coherence invalidations.
module sargantana_icache_ifill_server #(
  parameter int PADDR_WIDTH = 40,
  parameter int LINE_WIDTH  = 256,
  parameter int BEAT_WIDTH  = 64,
  parameter int WAY_WIDTH   = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  sargantana_icache_ifill_server_if.slave bus,
  output logic busy_o,
  output logic overlap_err_o
);
  localparam int N_BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [CNT_W-1:0]       LAST_BEAT = CNT_W'(N_BEATS - 1);
  localparam logic [PADDR_WIDTH-1:0] OFF_MASK  = PADDR_WIDTH'((LINE_WIDTH / 8) - 1);

  typedef enum logic [1:0] {IDLE, MEM_REQ, FILL, RESP} state_e;

  state_e                 state_q;
  logic [PADDR_WIDTH-1:0] addr_q;
  logic [WAY_WIDTH-1:0]   way_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [LINE_WIDTH-1:0]  line_q;
  logic                   mem_req_valid_q;
  logic                   overlap_q;
  logic                   resp_valid_q;
  logic [LINE_WIDTH-1:0]  resp_data_q;
  logic [1:0]             resp_beat_q;
  logic [WAY_WIDTH-1:0]   resp_way_q;
  logic                   resp_inv_q;
  logic [PADDR_WIDTH-1:0] resp_inv_paddr_q;
  logic                   inv_acc;

  // A registered invalidation response still on the bus blocks the next accept, so
  // invalidation responses can never pile up behind each other.
  assign bus.inv_ready_o = ~rst_i & (state_q == IDLE) & ~bus.ifill_req_valid_i & ~resp_inv_q;
  assign inv_acc         = bus.inv_ready_o & bus.inv_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      way_q            <= '0;
      cnt_q            <= '0;
      line_q           <= '0;
      mem_req_valid_q  <= 1'b0;
      overlap_q        <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_data_q      <= '0;
      resp_beat_q      <= '0;
      resp_way_q       <= '0;
      resp_inv_q       <= 1'b0;
      resp_inv_paddr_q <= '0;
    end else begin
      resp_valid_q     <= 1'b0;
      resp_data_q      <= '0;
      resp_beat_q      <= '0;
      resp_way_q       <= '0;
      resp_inv_q       <= 1'b0;
      resp_inv_paddr_q <= '0;
      if (bus.ifill_req_valid_i && state_q != IDLE) overlap_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (bus.ifill_req_valid_i) begin
            addr_q          <= bus.ifill_req_paddr_i & ~OFF_MASK;
            way_q           <= bus.ifill_req_way_i;
            cnt_q           <= '0;
            line_q          <= '0;
            mem_req_valid_q <= 1'b1;
            state_q         <= MEM_REQ;
          end else if (inv_acc) begin
            resp_valid_q     <= 1'b1;
            resp_inv_q       <= 1'b1;
            resp_inv_paddr_q <= bus.inv_paddr_i;
          end
        end
        MEM_REQ: begin
          if (bus.mem_req_ready_i) begin
            mem_req_valid_q <= 1'b0;
            cnt_q           <= '0;
            state_q         <= FILL;
          end
        end
        FILL: begin
          if (bus.mem_rsp_valid_i) begin
            line_q[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] <= bus.mem_rsp_data_i;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) state_q <= RESP;
          end
        end
        RESP: begin
          resp_valid_q <= 1'b1;
          resp_data_q  <= line_q;
          resp_beat_q  <= 2'(N_BEATS - 1);
          resp_way_q   <= way_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ifill_resp_valid_o     = resp_valid_q;
  assign bus.ifill_resp_data_o      = resp_data_q;
  assign bus.ifill_resp_beat_o      = resp_beat_q;
  assign bus.ifill_resp_way_o       = resp_way_q;
  assign bus.ifill_resp_inv_valid_o = resp_inv_q;
  assign bus.ifill_resp_inv_paddr_o = resp_inv_paddr_q;
  assign bus.mem_req_valid_o        = mem_req_valid_q;
  assign bus.mem_req_addr_o         = addr_q;
  assign busy_o                     = (state_q != IDLE);
  assign overlap_err_o              = overlap_q;
endmodule

// File: tb/tb_sargantana_icache_ifill_server.sv
// Bench for the icache refill server: random fills, backpressure, invalidations, collisions,
// overlapping requests and mid-fill reset, checked against a cycle-count/line-assembly model.
module tb_sargantana_icache_ifill_server;
  localparam int PA = 40, LW = 256, BW = 64, WW = 2, NB = 4;

  typedef struct {
    int            cyc;
    logic [LW-1:0] data;
    logic [1:0]    beat;
    logic [WW-1:0] way;
    logic          inv;
    logic [PA-1:0] ipa;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, ovl;
  int   cyc = 0;
  int   total = 0, bad = 0, z_bad = 0;
  rsp_t rq[$];
  int   acc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sargantana_icache_ifill_server_if #(.PADDR_WIDTH(PA), .LINE_WIDTH(LW), .BEAT_WIDTH(BW), .WAY_WIDTH(WW)) bus ();

  sargantana_icache_ifill_server #(.PADDR_WIDTH(PA), .LINE_WIDTH(LW), .BEAT_WIDTH(BW), .WAY_WIDTH(WW)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .busy_o(busy), .overlap_err_o(ovl));

  // Response log and invalidation-accept log, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.ifill_resp_valid_o)
      rq.push_back('{cyc, bus.ifill_resp_data_o, bus.ifill_resp_beat_o, bus.ifill_resp_way_o,
                     bus.ifill_resp_inv_valid_o, bus.ifill_resp_inv_paddr_o});
    else if (bus.ifill_resp_data_o != '0 || bus.ifill_resp_beat_o != '0 || bus.ifill_resp_way_o != '0 ||
             bus.ifill_resp_inv_valid_o != 1'b0 || bus.ifill_resp_inv_paddr_o != '0)
      z_bad++;
    if (bus.inv_valid_i && bus.inv_ready_o) acc_q.push_back(cyc);
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  function automatic logic [PA-1:0] line_addr(input logic [PA-1:0] pa);
    return {pa[PA-1:5], 5'b0};
  endfunction

  // Drives one fill as icache + memory. Beat k is preceded by gaps[k] idle cycles.
  task automatic run_fill(input logic [PA-1:0] pa, input logic [WW-1:0] w, input int dly,
                          input int gaps[NB], input bit junk, input int ovl_beat,
                          output logic [LW-1:0] line, output int t0, output int vcyc,
                          output bit addr_ok, output bit busy_ok, output logic rdy0);
    logic [BW-1:0] b;
    line = '0; addr_ok = 1'b1; busy_ok = 1'b1; vcyc = 0;
    bus.ifill_req_valid_i = 1'b1; bus.ifill_req_paddr_i = pa; bus.ifill_req_way_i = w;
    t0 = cyc;
    @(negedge clk); rdy0 = bus.inv_ready_o;
    nxt();
    bus.ifill_req_valid_i = 1'b0; bus.ifill_req_paddr_i = {8'($urandom), 32'($urandom)};
    bus.ifill_req_way_i = WW'($urandom);
    for (int i = 0; i <= dly; i++) begin
      bus.mem_req_ready_i = (i == dly);
      if (junk && i == dly) begin bus.mem_rsp_valid_i = 1'b1; bus.mem_rsp_data_i = {$urandom, $urandom}; end
      @(negedge clk);
      if (bus.mem_req_valid_o) vcyc++;
      if (bus.mem_req_addr_o !== line_addr(pa)) addr_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      nxt();
    end
    bus.mem_req_ready_i = 1'b0; bus.mem_rsp_valid_i = 1'b0;
    for (int k = 0; k < NB; k++) begin
      for (int g = 0; g < gaps[k]; g++) begin
        @(negedge clk); if (busy !== 1'b1) busy_ok = 1'b0;
        nxt();
      end
      b = {$urandom, $urandom};
      bus.mem_rsp_valid_i = 1'b1; bus.mem_rsp_data_i = b;
      line[k*BW +: BW] = b;
      if (k == ovl_beat) begin bus.ifill_req_valid_i = 1'b1; bus.ifill_req_paddr_i = {8'($urandom), 32'($urandom)}; end
      @(negedge clk); if (busy !== 1'b1) busy_ok = 1'b0;
      nxt();
      bus.mem_rsp_valid_i = 1'b0; bus.ifill_req_valid_i = 1'b0;
    end
  endtask

  task automatic wait_rsp(output bit got);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (rq.size() > 0) break;
    end
    got = (rq.size() > 0);
    nxt();
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (bus.ifill_resp_valid_o !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got %b exp 0", bus.ifill_resp_valid_o); end
    total++; if (bus.ifill_resp_data_o !== '0) begin bad++; $display("FAIL rst_resp_data got %h exp 0", bus.ifill_resp_data_o); end
    total++; if ({bus.ifill_resp_beat_o, bus.ifill_resp_way_o, bus.ifill_resp_inv_valid_o, bus.ifill_resp_inv_paddr_o} !== '0)
      begin bad++; $display("FAIL rst_resp_fields got nonzero exp 0"); end
    total++; if (bus.inv_ready_o !== 1'b0) begin bad++; $display("FAIL rst_inv_ready got %b exp 0", bus.inv_ready_o); end
    total++; if (bus.mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL rst_mem_req_valid got %b exp 0", bus.mem_req_valid_o); end
    total++; if (bus.mem_req_addr_o !== '0) begin bad++; $display("FAIL rst_mem_req_addr got %h exp 0", bus.mem_req_addr_o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b exp 0", busy); end
    total++; if (ovl !== 1'b0) begin bad++; $display("FAIL rst_overlap got %b exp 0", ovl); end
    nxt(); rst = 1'b0; nxt();
  endtask

  task automatic test_basic();
    int g[NB]; logic [LW-1:0] line; int t0, vc; bit aok, bok, got; logic r0; rsp_t r;
    g = '{0, 0, 0, 0}; rq.delete();
    // fixed beat values via a dedicated drive sequence
    bus.ifill_req_valid_i = 1'b1; bus.ifill_req_paddr_i = 40'h80001234; bus.ifill_req_way_i = 2'd2; t0 = cyc;
    nxt(); bus.ifill_req_valid_i = 1'b0; bus.mem_req_ready_i = 1'b1;
    @(negedge clk);
    total++; if (bus.mem_req_valid_o !== 1'b1 || bus.mem_req_addr_o !== 40'h80001220)
      begin bad++; $display("FAIL basic_mem_req got v=%b a=%h exp v=1 a=80001220", bus.mem_req_valid_o, bus.mem_req_addr_o); end
    nxt(); bus.mem_req_ready_i = 1'b0;
    line = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    for (int k = 0; k < NB; k++) begin
      bus.mem_rsp_valid_i = 1'b1; bus.mem_rsp_data_i = line[k*BW +: BW]; nxt();
    end
    bus.mem_rsp_valid_i = 1'b0;
    wait_rsp(got);
    total++; if (!got) begin bad++; $display("FAIL basic_resp got none exp one"); end
    if (got) begin
      r = rq.pop_front();
      total++; if (r.cyc !== t0 + 7) begin bad++; $display("FAIL basic_latency got %0d exp %0d", r.cyc - t0, 7); end
      total++; if (r.data !== line) begin bad++; $display("FAIL basic_data got %h exp %h", r.data, line); end
      total++; if (r.beat !== 2'd3 || r.way !== 2'd2 || r.inv !== 1'b0)
        begin bad++; $display("FAIL basic_fields got beat=%0d way=%0d inv=%b exp 3 2 0", r.beat, r.way, r.inv); end
    end
    // keep the generic driver exercised with the same zero-wait shape
    run_fill(40'h0000_0ABC_DE, 2'd1, 0, g, 1'b0, -1, line, t0, vc, aok, bok, r0);
    wait_rsp(got);
    total++; if (!got || rq[0].cyc !== t0 + 7 || rq[0].data !== line)
      begin bad++; $display("FAIL basic2 got n=%0d exp one line at +7", rq.size()); end
    rq.delete();
  endtask

  task automatic test_backpressure();
    int g[NB]; logic [LW-1:0] line; int t0, vc; bit aok, bok, got; logic r0; logic [PA-1:0] pa;
    g = '{0, 0, 3, 0}; rq.delete(); pa = {8'($urandom), 32'($urandom)};
    run_fill(pa, 2'd3, 5, g, 1'b1, -1, line, t0, vc, aok, bok, r0);
    wait_rsp(got); repeat (3) nxt();
    total++; if (vc !== 6) begin bad++; $display("FAIL bp_req_cycles got %0d exp 6", vc); end
    total++; if (!aok) begin bad++; $display("FAIL bp_addr_stable got unstable exp %h", line_addr(pa)); end
    total++; if (!bok) begin bad++; $display("FAIL bp_busy got low exp high"); end
    total++; if (rq.size() !== 1) begin bad++; $display("FAIL bp_resp_count got %0d exp 1", rq.size()); end
    if (rq.size() > 0) begin
      total++; if (rq[0].data !== line || rq[0].cyc !== t0 + 7 + 5 + 3)
        begin bad++; $display("FAIL bp_resp got %h @%0d exp %h @%0d", rq[0].data, rq[0].cyc - t0, line, 15); end
    end
    rq.delete();
  endtask

  task automatic test_random_fills();
    int g[NB]; logic [LW-1:0] line; int t0, vc, dly, gs, errs; bit aok, bok, got, junk; logic r0;
    logic [PA-1:0] pa; logic [WW-1:0] w; rsp_t r;
    for (int it = 0; it < 8; it++) begin
      rq.delete(); errs = 0;
      pa = {8'($urandom), 32'($urandom)}; w = WW'($urandom); dly = $urandom_range(3, 0); junk = 1'($urandom);
      gs = 0; for (int k = 0; k < NB; k++) begin g[k] = $urandom_range(2, 0); gs += g[k]; end
      run_fill(pa, w, dly, g, junk, -1, line, t0, vc, aok, bok, r0);
      wait_rsp(got);
      if (got) begin
        r = rq.pop_front();
        if (r.data !== line || r.way !== w || r.beat !== 2'd3 || r.inv !== 1'b0 || r.cyc !== t0 + 7 + dly + gs) errs++;
      end
      total++; if (!got || errs != 0 || vc != dly + 1 || !aok || !bok)
        begin bad++; $display("FAIL rand_fill it=%0d got got=%b errs=%0d vc=%0d exp vc=%0d", it, got, errs, vc, dly + 1); end
    end
    rq.delete();
  endtask

  task automatic test_inval();
    logic [PA-1:0] p; int t;
    for (int i = 0; i < 2; i++) begin
      rq.delete();
      p = (i == 0) ? 40'h1000 : {8'($urandom), 32'($urandom)};
      bus.inv_valid_i = 1'b1; bus.inv_paddr_i = p; t = cyc;
      @(negedge clk);
      total++; if (bus.inv_ready_o !== 1'b1) begin bad++; $display("FAIL inv_ready got %b exp 1", bus.inv_ready_o); end
      nxt(); bus.inv_valid_i = 1'b0;
      @(negedge clk); #1;
      total++; if (rq.size() !== 1) begin bad++; $display("FAIL inv_resp_count got %0d exp 1", rq.size()); end
      if (rq.size() > 0) begin
        total++; if (rq[0].cyc !== t + 1 || rq[0].inv !== 1'b1 || rq[0].ipa !== p || rq[0].data !== '0 ||
                     rq[0].beat !== 2'd0 || rq[0].way !== '0)
          begin bad++; $display("FAIL inv_resp got inv=%b pa=%h @%0d exp inv=1 pa=%h @1", rq[0].inv, rq[0].ipa, rq[0].cyc - t, p); end
      end
      nxt();
    end
    rq.delete();
  endtask

  task automatic test_collision();
    int g[NB]; logic [LW-1:0] line; int t0, vc; bit aok, bok, got; logic r0; logic [PA-1:0] p;
    g = '{0, 1, 0, 0}; rq.delete(); acc_q.delete(); p = {8'($urandom), 32'($urandom)};
    bus.inv_valid_i = 1'b1; bus.inv_paddr_i = p;
    run_fill(40'h55_0000_1F3C, 2'd1, 1, g, 1'b0, -1, line, t0, vc, aok, bok, r0);
    wait_rsp(got);
    bus.inv_valid_i = 1'b0;
    @(negedge clk); #1;
    total++; if (r0 !== 1'b0) begin bad++; $display("FAIL coll_ready_at_req got %b exp 0", r0); end
    total++; if (rq.size() !== 2) begin bad++; $display("FAIL coll_resp_count got %0d exp 2", rq.size()); end
    if (rq.size() == 2) begin
      total++; if (rq[0].inv !== 1'b0 || rq[0].data !== line || rq[0].cyc !== t0 + 9)
        begin bad++; $display("FAIL coll_fill got inv=%b @%0d exp inv=0 @9", rq[0].inv, rq[0].cyc - t0); end
      total++; if (acc_q.size() !== 1 || acc_q[0] !== rq[0].cyc)
        begin bad++; $display("FAIL coll_accept got n=%0d exp one at fill response cycle", acc_q.size()); end
      total++; if (rq[1].inv !== 1'b1 || rq[1].ipa !== p || rq[1].cyc !== rq[0].cyc + 1)
        begin bad++; $display("FAIL coll_inv got inv=%b pa=%h exp inv=1 pa=%h", rq[1].inv, rq[1].ipa, p); end
    end
    nxt(); rq.delete(); acc_q.delete();
  endtask

  task automatic test_overlap();
    int g[NB]; logic [LW-1:0] line; int t0, vc; bit aok, bok, got; logic r0;
    g = '{0, 0, 0, 0}; rq.delete();
    total++; if (ovl !== 1'b0) begin bad++; $display("FAIL ovl_pre got %b exp 0", ovl); end
    run_fill(40'h12_3456_7890, 2'd0, 0, g, 1'b0, 1, line, t0, vc, aok, bok, r0);
    wait_rsp(got); repeat (4) nxt();
    total++; if (ovl !== 1'b1) begin bad++; $display("FAIL ovl_sticky got %b exp 1", ovl); end
    total++; if (rq.size() !== 1 || (rq.size() > 0 && (rq[0].data !== line || rq[0].cyc !== t0 + 7)))
      begin bad++; $display("FAIL ovl_fill got n=%0d exp one correct line", rq.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovl_dropped got busy=%b exp 0", busy); end
    rq.delete();
  endtask

  task automatic test_reset_mid();
    int g[NB]; logic [LW-1:0] line; int t0, vc; bit aok, bok, got; logic r0;
    g = '{0, 0, 0, 0}; rq.delete();
    bus.ifill_req_valid_i = 1'b1; bus.ifill_req_paddr_i = 40'h77_7777_7777; nxt();
    bus.ifill_req_valid_i = 1'b0; bus.mem_req_ready_i = 1'b1; nxt(); bus.mem_req_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin bus.mem_rsp_valid_i = 1'b1; bus.mem_rsp_data_i = {$urandom, $urandom}; nxt(); end
    bus.mem_rsp_valid_i = 1'b0;
    rst = 1'b1; #1;
    total++; if ({bus.mem_req_valid_o, busy, ovl, bus.ifill_resp_valid_o, bus.inv_ready_o} !== 5'b0)
      begin bad++; $display("FAIL rmid_outputs got %b exp 00000",
                            {bus.mem_req_valid_o, busy, ovl, bus.ifill_resp_valid_o, bus.inv_ready_o}); end
    nxt(); rst = 1'b0;
    for (int k = 0; k < 2; k++) begin bus.mem_rsp_valid_i = 1'b1; bus.mem_rsp_data_i = {$urandom, $urandom}; nxt(); end
    bus.mem_rsp_valid_i = 1'b0; nxt();
    total++; if (rq.size() !== 0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_no_resp got n=%0d busy=%b exp 0 0", rq.size(), busy); end
    run_fill(40'h2000, 2'd3, 0, g, 1'b0, -1, line, t0, vc, aok, bok, r0);
    wait_rsp(got);
    total++; if (!got || rq[0].data !== line || rq[0].way !== 2'd3 || !aok)
      begin bad++; $display("FAIL rmid_refill got got=%b exp new line for 0x2000", got); end
    rq.delete();
  endtask

  task automatic test_idle_zero();
    total++; if (z_bad !== 0) begin bad++; $display("FAIL idle_fields_zero got %0d nonzero cycles exp 0", z_bad); end
  endtask

  initial begin
    bus.ifill_req_valid_i = 1'b0; bus.ifill_req_paddr_i = '0; bus.ifill_req_way_i = '0;
    bus.inv_valid_i = 1'b0; bus.inv_paddr_i = '0;
    bus.mem_req_ready_i = 1'b0; bus.mem_rsp_valid_i = 1'b0; bus.mem_rsp_data_i = '0;
    rst = 1'b1;
    nxt(); nxt();
    test_reset();
    test_basic();
    test_backpressure();
    test_random_fills();
    test_inval();
    test_collision();
    test_overlap();
    test_reset_mid();
    test_idle_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sargantana_icache_ifill_server.md
Name: sargantana_icache_ifill_server

Overview:
Upper-level responder for the instruction-cache refill interface. Accepts one line-fill request at a time from the icache, issues an aligned line read to the memory side, and collects N_BEATS in-order data beats. It then returns the whole cache line to the icache in a single-cycle response. In idle cycles it also forwards line invalidations from the coherence side as invalidation responses on the same response channel.

Parameters:
PADDR_WIDTH, 40, physical address width
LINE_WIDTH, 256, cache-line width in bits (32 B line, 5 offset bits)
BEAT_WIDTH, 64, memory data beat width; N_BEATS = LINE_WIDTH/BEAT_WIDTH = 4
WAY_WIDTH, 2, width of the way tag echoed back with the line

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
ifill_req_valid_i  in  1  icache line-fill request, single-cycle pulse, no ready
ifill_req_paddr_i  in  PADDR_WIDTH  line physical address
ifill_req_way_i  in  WAY_WIDTH  way chosen for replacement
ifill_resp_valid_o  out  1  response pulse (fill or invalidation)
ifill_resp_data_o  out  LINE_WIDTH  assembled line, beat k at bits [k*BEAT_WIDTH +: BEAT_WIDTH]
ifill_resp_beat_o  out  2  index of last beat received (N_BEATS-1 on fill, 0 on inval)
ifill_resp_way_o  out  WAY_WIDTH  echoed way
ifill_resp_inv_valid_o  out  1  response is an invalidation
ifill_resp_inv_paddr_o  out  PADDR_WIDTH  invalidated line address
inv_valid_i  in  1  invalidation request from coherence side
inv_paddr_i  in  PADDR_WIDTH  line to invalidate
inv_ready_o  out  1  invalidation accepted this cycle when high with inv_valid_i
mem_req_valid_o  out  1  memory line-read request
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o  out  PADDR_WIDTH  line-aligned address (low 5 bits zero)
mem_rsp_valid_i  in  1  memory data beat valid
mem_rsp_data_i  in  BEAT_WIDTH  data beat, in ascending order
busy_o  out  1  fill in progress (state != IDLE)
overlap_err_o  out  1  sticky: fill request seen while not IDLE

Behaviour:
- Reset (async, rst_i high): state IDLE; beat counter 0; line buffer 0; all outputs 0, including overlap_err_o.
- FSM states: IDLE, MEM_REQ, FILL, RESP.
- IDLE:
  - ifill_req_valid_i=1: capture paddr with bits[4:0] cleared, capture way, go to MEM_REQ next cycle.
  - Otherwise, if inv_valid_i=1: inv_ready_o=1 combinationally. Next cycle, emit one-cycle response with inv_valid=1, inv_paddr latched, data 0, beat 0, way 0. Stay IDLE.
  - inv_ready_o = (state==IDLE) & ~ifill_req_valid_i & ~inv_resp_pending. A fill request beats an invalidation in the same cycle.
- MEM_REQ:
  - mem_req_valid_o=1 with captured address, held stable until mem_req_ready_i.
  - On handshake go to FILL with counter 0.
  - A beat arriving in the handshake cycle is ignored; memory must not return data before acceptance.
- FILL:
  - Each mem_rsp_valid_i writes the beat into slot counter and increments counter.
  - On beat N_BEATS-1 go to RESP.
  - Beats may have gaps of any length; there is no timeout.
- RESP:
  - One cycle: ifill_resp_valid_o=1, full line, beat=N_BEATS-1, way echoed, inv_valid=0.
  - Next state IDLE; a new request may be accepted in the following cycle.
  - Fill-request-to-response minimum latency: 1 (capture) + 1 (mem handshake) + N_BEATS + 1 = 7 cycles with zero memory wait.
- ifill_req_valid_i while state != IDLE:
  - Request dropped; overlap_err_o set and held until reset. The icache guarantees one outstanding fill.
- mem_rsp_valid_i outside FILL: ignored.
- Response outputs registered. Data, beat, way and inv fields are 0 whenever ifill_resp_valid_o=0.
- Fill and invalidation responses never coincide; an invalidation pending from the IDLE accept cycle is emitted before any fill response.
- Reset mid-fill: partial line discarded, no response produced, memory-side beats still in flight after reset are ignored in IDLE.

Test Plan:
- Basic fill: req paddr=0x80001234, way=2; mem ready immediately; beats 0x11..,0x22..,0x33..,0x44.. back-to-back -> mem_req_addr_o=0x80001220; resp 7 cycles after req; data = {0x44..,0x33..,0x22..,0x11..}; beat=3; way=2.
- Backpressure and gaps: mem_req_ready_i low 5 cycles, 3-cycle gap between beats 1 and 2 -> mem_req_valid_o stable for 6 cycles with address unchanged; single response pulse with the correct line; busy_o high throughout.
- Invalidation: inv_valid_i with paddr=0x1000 in IDLE -> inv_ready_o=1 same cycle; next cycle resp valid=1, inv_valid=1, inv_paddr=0x1000, data=0.
- Collision: ifill_req_valid_i and inv_valid_i in the same IDLE cycle -> inv_ready_o=0; fill proceeds; inv accepted on first IDLE cycle after the fill response.
- Overlap: second fill request during FILL -> ignored; overlap_err_o=1 and sticky; first fill completes normally.
- Reset mid-fill: assert rst_i after 2 beats -> all outputs 0 immediately; a subsequent clean fill of 0x2000 returns only the new line data.
